lfsr_checker: RTL and testbench



---
 rtl/lfsr_checker_pkg.sv | 23 ++
 rtl/lfsr_check_window.sv | 42 ++++
 rtl/lfsr_checker.sv | 130 +++++++++++++
 tb/tb_lfsr_checker.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the 4-bit LFSR sequence checker.
// Latency: n/a (constants, types and a helper function only).
// Flow control: n/a.
package lfsr_checker_pkg;

  localparam int LFSR_W      = 4;
  localparam int LFSR_PERIOD = 15;

  // The generator's reset seed; its stream is 1,0,0,1,1,0,1,0,1,1,1,1,0,0,0.
  localparam logic [LFSR_W-1:0] GEN_SEED = 4'b1001;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Next bit of the sequence, from a history with h[0] as the oldest bit.
  function automatic logic predict(input logic [LFSR_W-1:0] h);
    return h[0] ^ h[1];
  endfunction

endpackage

// File: rtl/lfsr_check_window.sv
// Counts mismatches inside consecutive 15-bit windows while locked.
// Latency: loss is combinational on the current advance; counters update on the edge.
// Flow control: counters move only when advance is high; clear holds them at zero.
module lfsr_check_window
  import lfsr_checker_pkg::*;
#(
  parameter int LOSS_THRESH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  input  logic mismatch,
  output logic loss
);

  logic [3:0] wpos;
  logic [3:0] werr;
  logic [4:0] werr_inc;

  // Include the current mismatch before testing the threshold, so the bit
  // that completes the burst is the one that drops lock (even on a wrap bit).
  assign werr_inc = {1'b0, werr} + {4'b0000, mismatch};
  assign loss     = advance && mismatch && (werr_inc >= 5'(LOSS_THRESH));

  // Window position 0..14 and error tally; the tally restarts on every wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wpos <= '0;
      werr <= '0;
    end else if (advance) begin
      if (wpos == 4'(LFSR_PERIOD - 1)) begin
        wpos <= '0;
        werr <= '0;
      end else begin
        wpos <= wpos + 4'd1;
        werr <= werr_inc[3:0];
      end
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker: seeds from the stream, verifies the recurrence, then flywheels and counts errors.
// Latency: all outputs registered; err pulses the cycle after the mismatching sample.
// Flow control: din_valid low freezes all state (err reads 0); clr_count acts on any edge.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int LOCK_COUNT  = 8,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_count,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             expected
);

  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  state_t            state, state_n;
  logic [LFSR_W-1:0] h, h_n;
  logic [2:0]        fill, fill_n;
  logic [3:0]        mcnt, mcnt_n;
  logic              err_n;
  logic [ERR_W-1:0]  cnt_n;
  logic              p;
  logic              mismatch;
  logic              loss;
  logic              win_clear;
  logic              win_advance;

  assign p           = predict(h);
  assign mismatch    = din ^ p;
  assign win_clear   = (state != ST_LOCKED);
  assign win_advance = din_valid && (state == ST_LOCKED);

  lfsr_check_window #(
    .LOSS_THRESH(LOSS_THRESH)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .clear   (win_clear),
    .advance (win_advance),
    .mismatch(mismatch),
    .loss    (loss)
  );

  // Next-state, history and counter updates for one valid sample.
  always_comb begin
    state_n = state;
    h_n     = h;
    fill_n  = fill;
    mcnt_n  = mcnt;
    err_n   = 1'b0;
    cnt_n   = err_count;
    if (din_valid) begin
      unique case (state)
        ST_SEED: begin
          h_n    = {din, h[LFSR_W-1:1]};
          fill_n = (fill == 3'd4) ? fill : fill + 3'd1;
          // 0000 never occurs in the legal stream, so keep shifting past it.
          if ((fill_n == 3'd4) && (h_n != '0)) begin
            state_n = ST_VERIFY;
            mcnt_n  = '0;
          end
        end
        ST_VERIFY: begin
          if (!mismatch) begin
            h_n    = {din, h[LFSR_W-1:1]};
            mcnt_n = mcnt + 4'd1;
            if (mcnt_n == 4'(LOCK_COUNT)) state_n = ST_LOCKED;
          end else begin
            state_n = ST_SEED;
            fill_n  = '0;
            h_n     = '0;
            mcnt_n  = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel on our own prediction so a corrupted bit never enters h.
          h_n = {p, h[LFSR_W-1:1]};
          if (mismatch) begin
            err_n = 1'b1;
            if (err_count != CNT_MAX) cnt_n = err_count + 1'b1;
          end
          if (loss) begin
            state_n = ST_SEED;
            fill_n  = '0;
            h_n     = '0;
          end
        end
        default: begin
          state_n = ST_SEED;
          fill_n  = '0;
          h_n     = '0;
          mcnt_n  = '0;
        end
      endcase
    end
    if (clr_count) cnt_n = '0;
  end

  // State and registered outputs; rst overrides everything including din_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEED;
      h         <= '0;
      fill      <= '0;
      mcnt      <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      expected  <= 1'b0;
    end else begin
      state     <= state_n;
      h         <= h_n;
      fill      <= fill_n;
      mcnt      <= mcnt_n;
      locked    <= (state_n == ST_LOCKED);
      err       <= err_n;
      err_count <= cnt_n;
      expected  <= predict(h_n);
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default, and ERR_W=2 / LOSS_THRESH=10) on shared stimulus,
// each checked every cycle against a behavioural model, plus literal timing/count expectations.
// Stimulus is driven on the falling edge; the model steps on the rising edge.
module tb_lfsr_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clr_count = 1'b0;

  logic       locked0, err0, exp0;
  logic [7:0] cnt0;
  logic       locked1, err1, exp1;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_COUNT(8), .LOSS_THRESH(4), .ERR_W(8)) u0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_count(clr_count),
    .locked(locked0), .err(err0), .err_count(cnt0), .expected(exp0));

  lfsr_checker #(.LOCK_COUNT(8), .LOSS_THRESH(10), .ERR_W(2)) u1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_count(clr_count),
    .locked(locked1), .err(err1), .err_count(cnt1), .expected(exp1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // ---------------- behavioural model (one per instance) ----------------
  localparam int LOCK_N = 8;
  function automatic int loss_of(input int k); return (k == 0) ? 4 : 10; endfunction
  function automatic int max_of(input int k);  return (k == 0) ? 255 : 3; endfunction

  // mode: 0 = seeding, 1 = verifying, 2 = locked
  int m_mode [2];
  int m_hist [2][4];   // [0] is the oldest bit
  int m_fill [2];
  int m_match[2];
  int m_wpos [2];
  int m_werr [2];
  int m_cnt  [2];
  int m_err  [2];
  int m_lock [2];
  int m_exp  [2];
  bit model_ready = 1'b0;

  task automatic m_push(input int k, input int b);
    for (int i = 0; i < 3; i++) m_hist[k][i] = m_hist[k][i+1];
    m_hist[k][3] = b;
  endtask

  task automatic m_restart(input int k);
    m_mode[k] = 0; m_fill[k] = 0; m_match[k] = 0;
    for (int i = 0; i < 4; i++) m_hist[k][i] = 0;
  endtask

  task automatic model_step(input int k);
    int p;
    int d;
    m_err[k] = 0;
    if (rst) begin
      m_restart(k);
      m_wpos[k] = 0; m_werr[k] = 0; m_cnt[k] = 0;
    end else begin
      if (din_valid) begin
        d = int'(din);
        p = m_hist[k][0] ^ m_hist[k][1];
        case (m_mode[k])
          0: begin
            m_push(k, d);
            if (m_fill[k] < 4) m_fill[k]++;
            if (m_fill[k] == 4 && (m_hist[k][0] + m_hist[k][1] + m_hist[k][2] + m_hist[k][3]) != 0) begin
              m_mode[k] = 1; m_match[k] = 0;
            end
          end
          1: begin
            if (d == p) begin
              m_push(k, d);
              m_match[k]++;
              if (m_match[k] == LOCK_N) begin
                m_mode[k] = 2; m_wpos[k] = 0; m_werr[k] = 0;
              end
            end else m_restart(k);
          end
          default: begin
            m_push(k, p);
            if (d != p) begin
              m_err[k] = 1;
              if (m_cnt[k] < max_of(k)) m_cnt[k]++;
              m_werr[k]++;
            end
            if (m_werr[k] >= loss_of(k)) m_restart(k);
            else if (m_wpos[k] == 14) begin m_wpos[k] = 0; m_werr[k] = 0; end
            else m_wpos[k]++;
          end
        endcase
      end
      if (clr_count) m_cnt[k] = 0;
    end
    m_lock[k] = (m_mode[k] == 2) ? 1 : 0;
    m_exp[k]  = m_hist[k][0] ^ m_hist[k][1];
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (rst) model_ready = 1'b1;
  end

  // Per-cycle comparison against the model; also tallies err pulses of u0.
  int err_pulses0 = 0;
  always @(negedge clk) begin
    if (model_ready) begin
      chk("locked0", int'(locked0), m_lock[0]);
      chk("err0",    int'(err0),    m_err[0]);
      chk("count0",  int'(cnt0),    m_cnt[0]);
      if (m_mode[0] != 0) chk("expected0", int'(exp0), m_exp[0]);
      chk("locked1", int'(locked1), m_lock[1]);
      chk("err1",    int'(err1),    m_err[1]);
      chk("count1",  int'(cnt1),    m_cnt[1]);
      if (m_mode[1] != 0) chk("expected1", int'(exp1), m_exp[1]);
      if (err0) err_pulses0++;
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] gq = 4'b1001;

  task automatic cyc(input logic d, input logic v, input logic c, input logic r);
    @(negedge clk);
    din = d; din_valid = v; clr_count = c; rst = r;
  endtask

  task automatic gen_adv();
    gq = {gq[0] ^ gq[1], gq[3:1]};
  endtask

  task automatic send(input logic inv);
    cyc(gq[0] ^ inv, 1'b1, 1'b0, 1'b0);
    gen_adv();
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) send(1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    gq = 4'b1001;
  endtask

  initial begin
    logic [14:0] seq;
    int p0;

    // Generator pin: 15 bits from seed 1001.
    seq = '0;
    for (int i = 0; i < 15; i++) begin
      seq = {seq[13:0], gq[0]};
      gen_adv();
    end
    chk("gen_sequence", int'(seq), int'(15'b100110101111000));

    // Reset state.
    do_reset();
    settle();
    chk("rst_locked", int'(locked0), 0);
    chk("rst_err",    int'(err0),    0);
    chk("rst_count",  int'(cnt0),    0);
    chk("rst_expect", int'(exp0),    0);

    // Clean stream: lock exactly on the 12th bit, then 1000 clean bits.
    send_n(11);
    settle();
    chk("clean_lock_at_11", int'(locked0), 0);
    send(1'b0);
    settle();
    chk("clean_lock_at_12", int'(locked0), 1);
    p0 = err_pulses0;
    send_n(1000);
    settle();
    chk("clean_no_err", err_pulses0 - p0, 0);
    chk("clean_count",  int'(cnt0), 0);

    // Single inverted bit while locked.
    do_reset();
    send_n(12);
    p0 = err_pulses0;
    send(1'b1);
    settle();
    chk("single_err_pulse", int'(err0), 1);
    chk("single_count",     int'(cnt0), 1);
    send_n(30);
    settle();
    chk("single_locked",    int'(locked0), 1);
    chk("single_one_pulse", err_pulses0 - p0, 1);

    // Four-bit burst: lock drops on the 4th, relock after 12 clean bits.
    do_reset();
    send_n(12);
    for (int i = 0; i < 3; i++) send(1'b1);
    settle();
    chk("burst_locked_3", int'(locked0), 1);
    send(1'b1);
    settle();
    chk("burst_locked_4", int'(locked0), 0);
    chk("burst_count",    int'(cnt0),    4);
    send_n(11);
    settle();
    chk("relock_at_11", int'(locked0), 0);
    send(1'b0);
    settle();
    chk("relock_at_12", int'(locked0), 1);

    // Sixteen zeros, then the stream. The trailing zeros resemble the tail
    // of the sequence, so lock may come before the 12th stream bit.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("zeros_unlocked", int'(locked0), 0);
    gq = 4'b1001;
    send_n(12);
    settle();
    chk("zeros_locked_by_12", int'(locked0), 1);

    // Valid gaps: lock timing counts valid bits only.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send(1'b0);
      cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
    settle();
    chk("gaps_lock_at_11", int'(locked0), 0);
    send(1'b0);
    settle();
    chk("gaps_lock_at_12", int'(locked0), 1);

    // Saturation, clear priority and reset on the ERR_W=2 instance.
    do_reset();
    send_n(12);
    for (int i = 0; i < 3; i++) send(1'b1);
    settle();
    chk("sat_count_3", int'(cnt1), 3);
    send(1'b1);
    settle();
    chk("sat_hold_3", int'(cnt1), 3);
    cyc(gq[0] ^ 1'b1, 1'b1, 1'b1, 1'b0);
    gen_adv();
    settle();
    chk("clr_count_zero", int'(cnt1), 0);
    chk("clr_err_pulse",  int'(err1), 1);
    send(1'b1);
    settle();
    chk("post_clr_count", int'(cnt1),    1);
    chk("post_clr_lock",  int'(locked1), 1);
    cyc(gq[0] ^ 1'b1, 1'b1, 1'b0, 1'b1);
    settle();
    chk("rst_mid_locked", int'(locked1), 0);
    chk("rst_mid_err",    int'(err1),    0);
    chk("rst_mid_count",  int'(cnt1),    0);
    chk("rst_mid_expect", int'(exp1),    0);

    // Randomized run: gaps, errors, bursts, clears, resets and phase jumps.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 200)      cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      else if (r < 250) send(1'b1);
      else if (r < 260) begin
        for (int j = 0; j < 4; j++) send(1'b1);
      end
      else if (r < 275) begin
        cyc(gq[0] ^ 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        gen_adv();
      end
      else if (r < 278) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      else if (r < 283) begin
        gq = 4'($urandom_range(1, 15));
        send(1'b0);
      end
      else send(1'b0);
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
